// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
//
// Issue and writeback sequencer for an external combinational ALU. Each
// instruction is accepted, its operands are read from an internal register
// file, the operands are presented to the ALU, and the ALU result is written
// back. One instruction completes every three cycles.
//
// Configuration macro: ALU_IMM_EN
//   defined   : in_use_imm = 1 selects in_imm as the B operand
//   undefined : B operand is always regfile[rs2]; in_imm/in_use_imm unused
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         instruction handshake (ready only in IDLE)
//   in_opcode                   ADD=0 XOR=1 OR=2 AND=3 SEQ=4 SLT=5 SL=6 SR=7
//   in_rd, in_rs1, in_rs2       destination / source register indices
//   in_imm, in_use_imm          immediate operand and its select
//   alu_a, alu_b, alu_op        operands and opcode to the external ALU
//   alu_out                     combinational ALU result
//   wb_valid, wb_rd, wb_data    one-cycle writeback pulse, index, value
//   op_err                      one-cycle pulse after accepting opcode > 7
//   dbg_sel, dbg_data           combinational register-file read port
// ---------------------------------------------------------------------------
module alu_issue #(
    parameter int N    = 16,
    parameter int NREG = 8,
    localparam int IW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_opcode,
    input  logic [IW-1:0] in_rd,
    input  logic [IW-1:0] in_rs1,
    input  logic [IW-1:0] in_rs2,
    input  logic [N-1:0]  in_imm,
    input  logic          in_use_imm,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [3:0]    alu_op,
    input  logic [N-1:0]  alu_out,
    output logic          wb_valid,
    output logic [IW-1:0] wb_rd,
    output logic [N-1:0]  wb_data,
    output logic          op_err,
    input  logic [IW-1:0] dbg_sel,
    output logic [N-1:0]  dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  res_q, res_d;
    logic [IW-1:0] rd_q, rd_d;
    logic [IW-1:0] wb_rd_q, wb_rd_d;
    logic          wb_valid_q, wb_valid_d;
    logic          op_err_q, op_err_d;

    logic [N-1:0]  rf_q [NREG];
    logic [N-1:0]  rf_d [NREG];
    logic          rf_we;

    logic [N-1:0]  rs1_val;
    logic [N-1:0]  rs2_val;
    logic [N-1:0]  b_sel;

    assign rs1_val = rf_q[in_rs1];
    assign rs2_val = rf_q[in_rs2];

`ifdef ALU_IMM_EN
    assign b_sel = in_use_imm ? in_imm : rs2_val;
`else
    assign b_sel = rs2_val;
    logic unused_imm;
    assign unused_imm = ^{in_use_imm, in_imm};
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        rd_d       = rd_q;
        wb_rd_d    = wb_rd_q;
        wb_valid_d = 1'b0;
        op_err_d   = 1'b0;
        rf_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_opcode[3]) begin
                        // Illegal opcode: spend one non-ready cycle in WB with
                        // wb_valid low so nothing is written, and leave the
                        // ALU operand registers untouched.
                        op_err_d = 1'b1;
                        state_d  = S_WB;
                    end else begin
                        op_d    = in_opcode;
                        rd_d    = in_rd;
                        a_d     = rs1_val;
                        b_d     = b_sel;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                res_d      = alu_out;
                wb_rd_d    = rd_q;
                wb_valid_d = 1'b1;
                state_d    = S_WB;
            end
            S_WB: begin
                // wb_valid_q distinguishes a real writeback from the
                // illegal-opcode cycle.
                rf_we   = wb_valid_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register 0 is hardwired to zero; other entries load on a matching write.
    assign rf_d[0] = '0;
    for (genvar gi = 1; gi < NREG; gi++) begin : g_rf
        assign rf_d[gi] = (rf_we && (wb_rd_q == IW'(gi))) ? res_q : rf_q[gi];
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            rd_q       <= '0;
            wb_rd_q    <= '0;
            wb_valid_q <= 1'b0;
            op_err_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            rd_q       <= rd_d;
            wb_rd_q    <= wb_rd_d;
            wb_valid_q <= wb_valid_d;
            op_err_q   <= op_err_d;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_op   = op_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = res_q;
    assign op_err   = op_err_q;
    assign dbg_data = rf_q[dbg_sel];

endmodule

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue
//
// Bench for alu_issue. Supplies a behavioural ALU on alu_out, drives directed
// and random instructions, and compares every handshake, ALU operand,
// writeback and register-file value against an array-based register model.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_alu_issue;

    localparam int N  = 16;
    localparam int IW = 3;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_opcode;
    logic [IW-1:0] in_rd, in_rs1, in_rs2;
    logic [N-1:0]  in_imm;
    logic          in_use_imm;
    logic [N-1:0]  alu_a, alu_b;
    logic [3:0]    alu_op;
    logic [N-1:0]  alu_out;
    logic          wb_valid;
    logic [IW-1:0] wb_rd;
    logic [N-1:0]  wb_data;
    logic          op_err;
    logic [IW-1:0] dbg_sel;
    logic [N-1:0]  dbg_data;

    alu_issue #(.N(N), .NREG(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .op_err     (op_err),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Behavioural ALU: SLT unsigned, shifts by b[3:0], SR arithmetic.
    function automatic logic [N-1:0] alu_fn(input logic [3:0] op,
                                            input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        logic [N-1:0] r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a ^ b;
            4'd2:    r = a | b;
            4'd3:    r = a & b;
            4'd4:    r = (a == b) ? N'(1) : N'(0);
            4'd5:    r = (a < b) ? N'(1) : N'(0);
            4'd6:    r = a << b[3:0];
            4'd7:    r = N'($signed(a) >>> b[3:0]);
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb alu_out = alu_fn(alu_op, alu_a, alu_b);

    // Reference state
    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] model_rf [8];
    logic [N-1:0] last_a, last_b, last_wb;
    logic [3:0]   last_op;
    logic [IW-1:0] last_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_rf[i] = '0;
        last_a  = '0;
        last_b  = '0;
        last_wb = '0;
        last_op = '0;
        last_rd = '0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_sel = IW'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(model_rf[i]));
        end
    endtask

    task automatic read_reg(input int idx, output logic [N-1:0] val);
        dbg_sel = IW'(idx);
        #1;
        val = dbg_data;
    endtask

    // Issue one instruction from the low clock phase, follow it to completion.
    task automatic issue(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                         input logic ui, input logic [N-1:0] imm, output logic [N-1:0] wb_seen);
        logic [N-1:0] ea, eb, er, rv;
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        in_opcode  = op;
        in_rd      = IW'(rd);
        in_rs1     = IW'(rs1);
        in_rs2     = IW'(rs2);
        in_use_imm = ui;
        in_imm     = imm;
        ea = model_rf[rs1];
`ifdef ALU_IMM_EN
        eb = ui ? imm : model_rf[rs2];
`else
        eb = model_rf[rs2];
`endif
        er = alu_fn(op, ea, eb);
        wb_seen = '0;
        @(posedge clk);
        @(negedge clk);
        if (op > 4'd7) begin
            check("err_pulse", 32'(op_err), 32'd1);
            check("err_ready", 32'(in_ready), 32'd0);
            check("err_nowb", 32'(wb_valid), 32'd0);
            check("err_alu_op_hold", 32'(alu_op), 32'(last_op));
            check("err_alu_a_hold", 32'(alu_a), 32'(last_a));
            in_valid = 1'b0;
            @(negedge clk);
            check("err_pulse_end", 32'(op_err), 32'd0);
            check("err_ready_back", 32'(in_ready), 32'd1);
            check("err_nowb2", 32'(wb_valid), 32'd0);
            check("err_wbdata_hold", 32'(wb_data), 32'(last_wb));
            sweep("err");
        end else begin
            // EXEC cycle
            check("exec_ready", 32'(in_ready), 32'd0);
            check("exec_wb", 32'(wb_valid), 32'd0);
            check("exec_err", 32'(op_err), 32'd0);
            check("alu_a", 32'(alu_a), 32'(ea));
            check("alu_b", 32'(alu_b), 32'(eb));
            check("alu_op", 32'(alu_op), 32'(op));
            // Junk on the input while busy must be ignored.
            in_opcode  = 4'($urandom_range(0, 15));
            in_rd      = IW'($urandom_range(0, 7));
            in_rs1     = IW'($urandom_range(0, 7));
            in_rs2     = IW'($urandom_range(0, 7));
            in_use_imm = 1'($urandom_range(0, 1));
            in_imm     = N'($urandom);
            @(negedge clk);
            // WB cycle
            check("wb_valid", 32'(wb_valid), 32'd1);
            check("wb_rd", 32'(wb_rd), 32'(rd));
            check("wb_data", 32'(wb_data), 32'(er));
            check("wb_ready", 32'(in_ready), 32'd0);
            check("wb_alu_a_hold", 32'(alu_a), 32'(ea));
            wb_seen = wb_data;
            read_reg(rd, rv);
            check("pre_write", 32'(rv), 32'(model_rf[rd]));
            in_valid = 1'b0;
            @(negedge clk);
            // Back in IDLE
            if (rd != 0) model_rf[rd] = er;
            last_a  = ea;
            last_b  = eb;
            last_op = op;
            last_wb = er;
            last_rd = IW'(rd);
            check("idle_wb_low", 32'(wb_valid), 32'd0);
            check("idle_ready", 32'(in_ready), 32'd1);
            check("wb_data_hold", 32'(wb_data), 32'(last_wb));
            check("wb_rd_hold", 32'(wb_rd), 32'(last_rd));
            check("alu_b_hold", 32'(alu_b), 32'(last_b));
            sweep("post");
        end
        $display("txn op=%0d rd=%0d rs1=%0d rs2=%0d ui=%0d imm=%h exp=%h seen=%h",
                 op, rd, rs1, rs2, ui, imm, er, wb_seen);
    endtask

    // Start an instruction and assert reset while it is in writeback.
    task automatic abort_in_wb(input logic [3:0] op, input int rd, input int rs1, input int rs2);
        in_valid   = 1'b1;
        in_opcode  = op;
        in_rd      = IW'(rd);
        in_rs1     = IW'(rs1);
        in_rs2     = IW'(rs2);
        in_use_imm = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_in_wb", 32'(wb_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("abort_wb_low", 32'(wb_valid), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_wbdata", 32'(wb_data), 32'd0);
        @(negedge clk);
        sweep("abort");
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_idle", 32'(in_ready), 32'd1);
        sweep("after_abort");
        $display("txn abort op=%0d rd=%0d during writeback", op, rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] ws, rv;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_opcode  = '0;
        in_rd      = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_imm     = '0;
        in_use_imm = 1'b0;
        dbg_sel    = '0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_wb", 32'(wb_valid), 32'd0);
        check("rst_err", 32'(op_err), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_wb_data", 32'(wb_data), 32'd0);
        sweep("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd1);

`ifdef ALU_IMM_EN
        issue(4'd0, 1, 0, 0, 1'b1, 16'h0005, ws);
        check("imm_add1", 32'(ws), 32'h0005);
        issue(4'd0, 2, 1, 0, 1'b1, 16'h00FF, ws);
        check("imm_add2", 32'(ws), 32'h0104);
        read_reg(2, rv);
        check("r2_0104", 32'(rv), 32'h0104);
        issue(4'd2, 1, 0, 0, 1'b1, 16'h8001, ws);
        issue(4'd7, 3, 1, 0, 1'b1, 16'h0001, ws);
        check("sr_c000", 32'(ws), 32'hC000);
        issue(4'd5, 4, 0, 1, 1'b0, 16'h0000, ws);
        check("slt_1", 32'(ws), 32'h0001);
        issue(4'd4, 5, 1, 1, 1'b0, 16'h0000, ws);
        check("seq_1", 32'(ws), 32'h0001);
        issue(4'd9, 2, 1, 1, 1'b0, 16'h0000, ws);
        issue(4'd0, 0, 0, 0, 1'b1, 16'h1234, ws);
        check("rd0_wb", 32'(ws), 32'h1234);
        read_reg(0, rv);
        check("rd0_zero", 32'(rv), 32'h0000);
        abort_in_wb(4'd1, 6, 1, 3);
`else
        issue(4'd4, 1, 0, 0, 1'b1, 16'h00AA, ws);
        check("seq_r0", 32'(ws), 32'h0001);
        issue(4'd0, 2, 1, 1, 1'b0, 16'h0000, ws);
        issue(4'd0, 3, 2, 2, 1'b1, 16'h0003, ws);
        issue(4'd0, 4, 3, 3, 1'b0, 16'h0000, ws);
        issue(4'd0, 5, 4, 3, 1'b0, 16'h0000, ws);
        issue(4'd0, 5, 5, 2, 1'b0, 16'h0000, ws);
        issue(4'd0, 5, 5, 1, 1'b0, 16'h0000, ws);
        check("shift15", 32'(ws), 32'h000F);
        issue(4'd6, 6, 1, 5, 1'b0, 16'h0000, ws);
        issue(4'd2, 6, 6, 1, 1'b0, 16'h0000, ws);
        check("r_8001", 32'(ws), 32'h8001);
        issue(4'd7, 7, 6, 1, 1'b1, 16'h0004, ws);
        check("sr_c000", 32'(ws), 32'hC000);
        issue(4'd5, 2, 0, 6, 1'b0, 16'h0000, ws);
        check("slt_1", 32'(ws), 32'h0001);
        issue(4'd4, 3, 6, 6, 1'b0, 16'h0000, ws);
        check("seq_1", 32'(ws), 32'h0001);
        issue(4'd9, 2, 1, 1, 1'b0, 16'h0000, ws);
        issue(4'd0, 0, 6, 0, 1'b0, 16'h0000, ws);
        check("rd0_wb", 32'(ws), 32'h8001);
        read_reg(0, rv);
        check("rd0_zero", 32'(rv), 32'h0000);
        abort_in_wb(4'd1, 6, 7, 1);
`endif

        // Seed a few registers, then random instruction mix.
        issue(4'd4, 1, 0, 0, 1'b0, 16'h0000, ws);
        issue(4'd6, 2, 1, 1, 1'b0, 16'h0000, ws);
        issue(4'd0, 3, 2, 1, 1'b0, 16'h0000, ws);
        for (int t = 0; t < 40; t++) begin
            issue(4'($urandom_range(0, 9)), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), 1'($urandom_range(0, 1)), N'($urandom), ws);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
